// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a synchronous FIFO: pops one byte per frame
// and shifts it out LSB first at CLKS_PER_BIT clocks per bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !fifo_empty) state_d = S_POP;
      end
      S_POP: state_d = S_LOAD;
      S_LOAD: begin
        shift_d = fifo_dout;
        baud_d  = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // tx takes the bit that becomes shift[0] after this shift
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = (tx_en && !fifo_empty) ? S_POP : S_IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = (state_q == S_POP);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_STOP) && baud_last;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a queue-based FIFO feeds the DUT, written
// bytes are expected frames, and a serial monitor decodes tx against them.
module tb_fifo_uart_tx;
  localparam int C = 4;
  localparam int FRAME = 10 * C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_en = 1'b0;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic fifo_rd_en, tx, busy, frame_done;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy),
    .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Behavioural synchronous FIFO: dout valid the cycle after rd_en
  logic [7:0] fq[$];
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  logic [7:0] exp_q[$];
  int writes = 0;

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    writes++;
    @(posedge clk); #2;
    wr_en = 1'b0;
  endtask

  // Serial monitor / decoder
  logic rst_edge = 1'b0;
  always @(posedge clk) rst_edge <= rst_n;

  int cyc = 0, off = 0, pops = 0, frames = 0, aborts = 0;
  int starts[$];
  bit active = 0;
  bit prev_rd = 0;
  logic [7:0] cur = 8'h00, rx = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (!rst_edge) begin
      chk("reset_outputs", {29'd0, tx, busy, fifo_rd_en}, 3'b100);
      if (active) begin
        active = 0;
        aborts++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end else begin
      if (fifo_rd_en) begin
        pops++;
        chk("pop_while_empty", int'(fifo_empty), 0);
        chk("rd_en_width", int'(prev_rd), 0);
      end
      if (!active && tx == 1'b0) begin
        active = 1;
        off = 0;
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("frame_expected", 0, 1);
          cur = 8'h00;
        end else cur = exp_q[0];
      end
      if (active) begin
        int k;
        logic eb;
        k = off / C;
        eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : cur[k-1];
        chk("tx_bit", int'(tx), int'(eb));
        if (k >= 1 && k <= 8 && (off % C) == C / 2) rx[k-1] = tx;
        chk("frame_done_pos", int'(frame_done), int'(off == FRAME - 1));
        if (off == FRAME - 1) begin
          chk("byte", int'(rx), int'(cur));
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          frames++;
          active = 0;
        end else off++;
      end else begin
        chk("frame_done_idle", int'(frame_done), 0);
        chk("tx_idle_high", int'(tx), 1);
      end
    end
    prev_rd = fifo_rd_en;
  end

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic wait_drained(input int budget);
    int n = 0;
    while (!(!busy && fifo_empty && !active) && n < budget) begin tick(); n++; end
    if (n >= budget) chk("drain_timeout", n, -1);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((busy || active) && n < budget) begin tick(); n++; end
    if (n >= budget) chk("quiet_timeout", n, -1);
  endtask

  int p0, f0, s0, a0, n_cyc;

  initial begin
    tick();
    // Reset held with a byte available: no pop, idle outputs
    push_byte(8'hA5);
    repeat (3) tick();
    chk("no_pop_in_reset", pops, 0);
    chk("empty_low_in_reset", int'(fifo_empty), 0);
    tx_en = 1'b1;
    rst_n = 1'b1;

    // Single byte 0xA5
    p0 = pops; f0 = frames;
    wait_drained(200);
    chk("single_pops", pops - p0, 1);
    chk("single_frames", frames - f0, 1);
    chk("single_idle_busy", int'(busy), 0);

    // Burst of three, back to back
    p0 = pops; s0 = starts.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    wait_drained(500);
    chk("burst_pops", pops - p0, 3);
    chk("burst_frames", starts.size() - s0, 3);
    if (starts.size() - s0 == 3) begin
      chk("burst_period_1", starts[s0+1] - starts[s0], FRAME + 2);
      chk("burst_period_2", starts[s0+2] - starts[s0+1], FRAME + 2);
    end

    // tx_en dropped mid-frame 1 of 2
    s0 = starts.size(); p0 = pops;
    push_byte(8'h11);
    push_byte(8'h22);
    begin
      int n = 0;
      while (!(active && off >= FRAME / 2) && n < 200) begin tick(); n++; end
      if (n >= 200) chk("gate_wait_timeout", n, -1);
    end
    tx_en = 1'b0;
    wait_quiet(200);
    repeat (20) tick();
    chk("gate_frames", starts.size() - s0, 1);
    chk("gate_pops", pops - p0, 1);
    chk("gate_fifo_holds", int'(fifo_empty), 0);
    tx_en = 1'b1;
    n_cyc = cyc + 1;  // first monitor cycle that sees tx_en high
    wait_drained(200);
    chk("gate_resume_frames", starts.size() - s0, 2);
    if (starts.size() - s0 == 2) chk("gate_resume_latency", starts[s0+1] - n_cyc, 3);

    // Reset during DATA bit 3
    s0 = starts.size(); a0 = aborts; f0 = frames;
    push_byte(8'h5A);
    push_byte(8'hC3);
    begin
      int n = 0;
      while (!(active && off >= 4 * C + 1) && n < 200) begin tick(); n++; end
      if (n >= 200) chk("rst_wait_timeout", n, -1);
    end
    rst_n = 1'b0;
    tick();
    #4;
    chk("rst_tx_high", int'(tx), 1);
    chk("rst_busy_low", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    wait_drained(300);
    chk("rst_aborts", aborts - a0, 1);
    chk("rst_frames_after", frames - f0, 1);

    // Random soak with random tx_en
    for (int i = 0; i < 100; i++) begin
      tx_en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) push_byte(8'($urandom));
      else tick();
    end
    tx_en = 1'b1;
    wait_drained(6000);

    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_fifo_empty", fq.size(), 0);
    chk("final_pops_eq_writes", pops, writes);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the 8-bit synchronous FIFO and sends each byte as an 8N1 UART frame. Sits directly downstream of the FIFO: it watches `empty`, issues single-cycle `rd_en` pops, captures `dout`, and shifts the byte out on `tx`. The block is fully synchronous to the FIFO clock, and the baud rate is set by a clock-divider parameter.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal values are integers ≥ 2.
- `DATA_W`, default 8: byte width. Must match the FIFO data width. Only 8 is supported.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst_n`, in, 1: synchronous reset, active-low. Sampled on the rising edge of `clk`.
- `tx_en`, in, 1: transmit enable. When low, no new pops are issued.
- `fifo_empty`, in, 1: FIFO `empty` flag.
- `fifo_dout`, in, 8: FIFO `dout`. Valid in the cycle after the cycle in which `rd_en` was high.
- `fifo_rd_en`, out, 1: FIFO `rd_en`. One-cycle pop strobe.
- `tx`, out, 1: serial line. Idle high. Registered.
- `busy`, out, 1: high in every state except IDLE.
- `frame_done`, out, 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, STOP.
- Counters:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..CLKS_PER_BIT-1.
  - Bit index: 3 bits, counts 0..7.
  - Shift register: 8 bits.
- Outputs are decoded from registered state only. `fifo_rd_en` = (state==POP) and `busy` = (state!=IDLE); both are glitch-free.
- IDLE
  - `tx`=1.
  - If `tx_en` && !`fifo_empty`, go to POP. Otherwise stay.
- POP
  - `fifo_rd_en`=1 for exactly this cycle. Always go to LOAD.
- LOAD
  - Capture `fifo_dout` into the shift register. Go to START with `tx` driven 0 at the same edge.
  - Clear the baud counter.
- START
  - `tx`=0 for CLKS_PER_BIT cycles.
  - On terminal count, go to DATA, `tx`=shift[0], bit index=0.
- DATA
  - Each bit lasts CLKS_PER_BIT cycles, LSB first.
  - On terminal count with bit index<7: shift right, increment the index, `tx`=next bit.
  - On terminal count with index=7: go to STOP, `tx`=1.
- STOP
  - `tx`=1 for CLKS_PER_BIT cycles. `frame_done`=1 in the final cycle.
  - On terminal count: if `tx_en` && !`fifo_empty`, go directly to POP. Otherwise go to IDLE.
- `fifo_rd_en` is only ever asserted after `fifo_empty`=0 was sampled. The block never pops an empty FIFO.
- Exactly one pop per frame. No byte is dropped or duplicated while `rst_n` stays high.
- `tx_en` low mid-frame: the current frame completes unchanged; only the next pop is suppressed. `tx_en` is ignored in POP and LOAD.
- `fifo_empty` rising during POP or LOAD has no effect: the byte is already committed.

## Timing
- Reset values:
  - `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0.
  - State=IDLE; counters and shift register = 0.
- `rst_n` low at any edge, including mid-frame: all of the above apply from that edge.
  - `tx` returns high immediately. A truncated frame is acceptable.
  - A byte already popped is discarded.
  - No pop occurs while `rst_n` is low.
- Latency, with cycle N = first IDLE cycle seeing `fifo_empty`=0 and `tx_en`=1:
  - POP at N+1, LOAD at N+2.
  - `tx` falls at the start of N+3.
- Frame length: exactly 10·CLKS_PER_BIT cycles of `tx` (start + 8 data + stop).
- Back-to-back frames: the stop bit is followed by POP and LOAD, giving exactly 2 idle-high cycles. Frame period = 10·CLKS_PER_BIT + 2 cycles.
- `frame_done` coincides with the last stop-bit cycle. It is never high in any other state.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `fifo_empty`=0. `tx`=1, `fifo_rd_en`=0, `busy`=0 throughout, and no pop is issued.
- Single byte, CLKS_PER_BIT=4, FIFO preloaded with 0xA5:
  - `fifo_rd_en` is high for exactly 1 cycle.
  - `tx` sequence in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1.
  - `frame_done` pulses once. The FIFO goes empty and the block returns to IDLE.
- Burst: FIFO preloaded with 0x00, 0xFF, 0x3C.
  - Three frames decode to 0x00, 0xFF, 0x3C in order.
  - Frame starts are 42 cycles apart (CLKS_PER_BIT=4).
  - Exactly 3 pops occur, with no pop after `empty`.
- `tx_en` gating:
  - Drop `tx_en` in the middle of frame 1 of 2. Frame 1 completes and frame 2 is not started.
  - Raise `tx_en`. Frame 2 begins 3 cycles later.
- Reset mid-frame: assert `rst_n`=0 during DATA bit 3. `tx`=1 and `busy`=0 from the next edge. After release, the next FIFO byte is sent intact.
- Random soak, integrated with the FIFO: 100 cycles of random writes. A serial decoder's captured stream equals the written stream exactly, and `rd_en` is never asserted while `empty`=1.
